forward_rotor0_stage: RTL and testbench

- Forward (entry-to-reflector) path through rotor 0: the leftward counterpart of the reverse rotor stage.
- Owns the rotor 0 position register and steps it once per accepted character before substitution.
- Emits a turnover carry for the next rotor.
- Pipelined two-stage substitution with a valid/ready handshake on both sides, sitting between the plugboard output and rotor 1's forward input.

---
 rtl/forward_rotor0_stage.sv | 132 +++++++++++++
 tb/tb_forward_rotor0_stage.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/forward_rotor0_stage.sv
// Rotor 0 forward path: owns the rotor position, steps it per accepted character,
// and substitutes through the wiring in a two-stage valid/ready pipeline.
module forward_rotor0_stage #(
  parameter logic [4:0] NOTCH       = 5'd16,
  parameter logic [4:0] RING        = 5'd0,
  parameter bit         STEP_ALWAYS = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_en,
  input  logic [4:0] load_pos,
  input  logic       in_valid,
  input  logic [4:0] in_data,
  output logic       in_ready,
  input  logic       step_in,
  output logic       out_valid,
  output logic [4:0] out_data,
  input  logic       out_ready,
  output logic       carry_out,
  output logic [4:0] position,
  output logic       err
);

  function automatic logic [4:0] wiring(input logic [4:0] i);
    case (i)
      5'd0:  wiring = 5'd4;   5'd1:  wiring = 5'd10;  5'd2:  wiring = 5'd12;
      5'd3:  wiring = 5'd5;   5'd4:  wiring = 5'd11;  5'd5:  wiring = 5'd6;
      5'd6:  wiring = 5'd3;   5'd7:  wiring = 5'd16;  5'd8:  wiring = 5'd21;
      5'd9:  wiring = 5'd25;  5'd10: wiring = 5'd13;  5'd11: wiring = 5'd19;
      5'd12: wiring = 5'd14;  5'd13: wiring = 5'd22;  5'd14: wiring = 5'd24;
      5'd15: wiring = 5'd7;   5'd16: wiring = 5'd23;  5'd17: wiring = 5'd20;
      5'd18: wiring = 5'd18;  5'd19: wiring = 5'd15;  5'd20: wiring = 5'd0;
      5'd21: wiring = 5'd8;   5'd22: wiring = 5'd1;   5'd23: wiring = 5'd17;
      5'd24: wiring = 5'd2;   5'd25: wiring = 5'd9;
      default: wiring = 5'd0;
    endcase
  endfunction

  logic [4:0] position_q, position_d;
  logic       s1_valid_q, s1_valid_d;
  logic [4:0] s1_idx_q, s1_idx_d;
  logic [4:0] s1_off_q, s1_off_d;
  logic       s1_inv_q, s1_inv_d;
  logic [4:0] s1_raw_q, s1_raw_d;
  logic       s2_valid_q, s2_valid_d;
  logic [4:0] out_data_q, out_data_d;
  logic       carry_q, carry_d;
  logic       err_q, err_d;

  logic       advance, accept, invalid, do_step;
  logic [4:0] p_new;
  logic [5:0] off_sum, off, idx_sum, idx, diff;

  always_comb begin
    advance  = !s2_valid_q | out_ready;
    in_ready = advance & !load_en;
    accept   = in_valid & in_ready;
    invalid  = (in_data >= 5'd26);
    do_step  = (STEP_ALWAYS | step_in) & !invalid;
    p_new    = position_q;
    if (do_step) p_new = (position_q == 5'd25) ? 5'd0 : position_q + 5'd1;

    // p_new <= 25 so the biased sum stays below 52; one subtract normalises it
    off_sum = {1'b0, p_new} + 6'd26 - {1'b0, RING};
    off     = (off_sum >= 6'd26) ? off_sum - 6'd26 : off_sum;
    idx_sum = {1'b0, in_data} + off;
    idx     = (idx_sum >= 6'd26) ? idx_sum - 6'd26 : idx_sum;

    diff = {1'b0, wiring(s1_idx_q)} - {1'b0, s1_off_q};
    if (diff[5]) diff = diff + 6'd26;

    position_d = position_q;
    s1_valid_d = s1_valid_q;
    s1_idx_d   = s1_idx_q;
    s1_off_d   = s1_off_q;
    s1_inv_d   = s1_inv_q;
    s1_raw_d   = s1_raw_q;
    s2_valid_d = s2_valid_q;
    out_data_d = out_data_q;

    if (load_en)     position_d = (load_pos >= 5'd26) ? 5'd0 : load_pos;
    else if (accept) position_d = p_new;

    if (advance) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_idx_d = idx[4:0];
        s1_off_d = off[4:0];
        s1_inv_d = invalid;
        s1_raw_d = in_data;
      end
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) out_data_d = s1_inv_q ? s1_raw_q : diff[4:0];
    end

    carry_d = accept & do_step & (position_q == NOTCH);
    err_d   = load_en ? 1'b0 : (err_q | (accept & invalid));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      position_q <= 5'd0;
      s1_valid_q <= 1'b0;
      s1_idx_q   <= 5'd0;
      s1_off_q   <= 5'd0;
      s1_inv_q   <= 1'b0;
      s1_raw_q   <= 5'd0;
      s2_valid_q <= 1'b0;
      out_data_q <= 5'd0;
      carry_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      position_q <= position_d;
      s1_valid_q <= s1_valid_d;
      s1_idx_q   <= s1_idx_d;
      s1_off_q   <= s1_off_d;
      s1_inv_q   <= s1_inv_d;
      s1_raw_q   <= s1_raw_d;
      s2_valid_q <= s2_valid_d;
      out_data_q <= out_data_d;
      carry_q    <= carry_d;
      err_q      <= err_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = out_data_q;
  assign carry_out = carry_q;
  assign position  = position_q;
  assign err       = err_q;

endmodule

// File: tb/tb_forward_rotor0_stage.sv
// Directed bench for forward_rotor0_stage with hand-computed expected letters.
module tb_forward_rotor0_stage;
  logic       clk = 1'b0;
  logic       rst;
  logic       load_en;
  logic [4:0] load_pos;
  logic       in_valid;
  logic [4:0] in_data;
  logic       in_ready;
  logic       step_in;
  logic       out_valid;
  logic [4:0] out_data;
  logic       out_ready;
  logic       carry_out;
  logic [4:0] position;
  logic       err;

  int n_chk  = 0;
  int n_pass = 0;

  forward_rotor0_stage dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_pos(load_pos),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .step_in(step_in), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .carry_out(carry_out), .position(position), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic do_load(input logic [4:0] p);
    load_en = 1'b1; load_pos = p;
    tick();
    load_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; load_pos = 5'd0; in_valid = 1'b0;
    in_data = 5'd0; step_in = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_position", position, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_carry", carry_out, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    tick();

    // A at position 0 -> steps to 1, J
    do_load(5'd0);
    in_valid = 1'b1; in_data = 5'd0;
    tick();
    in_valid = 1'b0;
    chk("t1_position", position, 1);
    chk("t1_carry", carry_out, 0);
    chk("t1_valid_early", out_valid, 0);
    tick();
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 9);
    tick();
    chk("t1_drain", out_valid, 0);

    // Wrap 25 -> 0, E
    do_load(5'd25);
    in_valid = 1'b1; in_data = 5'd0;
    tick();
    in_valid = 1'b0;
    chk("t2_position", position, 0);
    chk("t2_carry", carry_out, 0);
    tick();
    chk("t2_data", out_data, 4);
    chk("t2_valid", out_valid, 1);

    // Notch 16 -> 17 gives carry, D
    do_load(5'd16);
    chk("t3_load_no_carry", carry_out, 0);
    in_valid = 1'b1; in_data = 5'd0;
    tick();
    in_valid = 1'b0;
    chk("t3_position", position, 17);
    chk("t3_carry", carry_out, 1);
    tick();
    chk("t3_carry_gone", carry_out, 0);
    chk("t3_data", out_data, 3);

    // Stall: three A's at positions 1,2,3 -> 9,10,2
    do_load(5'd0);
    in_valid = 1'b1; in_data = 5'd0;
    tick();
    tick();
    chk("t4_first_valid", out_valid, 1);
    chk("t4_first_data", out_data, 9);
    out_ready = 1'b0;
    #1;
    chk("t4_in_ready_low", in_ready, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("t4_hold_data", out_data, 9);
    chk("t4_hold_valid", out_valid, 1);
    chk("t4_hold_position", position, 2);
    chk("t4_hold_in_ready", in_ready, 0);
    out_ready = 1'b1;
    #1;
    chk("t4_in_ready_high", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("t4_second_data", out_data, 10);
    chk("t4_position3", position, 3);
    tick();
    chk("t4_third_data", out_data, 2);
    chk("t4_third_valid", out_valid, 1);
    tick();
    chk("t4_drained", out_valid, 0);

    // Invalid code passes through, no step, sticky err
    do_load(5'd5);
    in_valid = 1'b1; in_data = 5'd27;
    tick();
    in_valid = 1'b0;
    chk("t5_position", position, 5);
    chk("t5_err", err, 1);
    tick();
    chk("t5_data", out_data, 27);
    tick();
    chk("t5_err_sticky", err, 1);
    do_load(5'd30);
    chk("t5_err_cleared", err, 0);
    chk("t5_load_oob", position, 0);

    // Async reset with characters in flight
    in_valid = 1'b1; in_data = 5'd0;
    tick();
    tick();
    in_valid = 1'b0;
    chk("t6_pre_position", position, 2);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_position", position, 0);
    #1 rst = 1'b0;
    tick();
    chk("t6_no_ghost", out_valid, 0);
    tick();
    chk("t6_no_ghost2", out_valid, 0);
    in_valid = 1'b1; in_data = 5'd0;
    tick();
    in_valid = 1'b0;
    tick();
    chk("t6_after_valid", out_valid, 1);
    chk("t6_after_data", out_data, 9);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
